// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the PRBS generator: symbol levels,
// Gray PAM-4 mapping and a table of maximal-length feedback masks.
package lfsr_pkg;

    localparam int SYM_W = 3;

    typedef logic signed [SYM_W-1:0] sym_t;

    // Output levels, two's complement in SYM_W bits
    localparam sym_t LVL_M3 = 3'sb101;
    localparam sym_t LVL_M1 = 3'sb111;
    localparam sym_t LVL_P1 = 3'sb001;
    localparam sym_t LVL_P3 = 3'sb011;

    localparam int OUT_2LVL = 0;
    localparam int OUT_PAM4 = 1;

    // Gray-coded PAM-4: adjacent levels differ in one bit
    function automatic sym_t gray_pam4(input logic [1:0] g);
        sym_t s;
        case (g)
            2'b00:   s = LVL_M3;
            2'b01:   s = LVL_M1;
            2'b11:   s = LVL_P1;
            default: s = LVL_P3;
        endcase
        return s;
    endfunction

    // Maximal-length masks; bit k-1 set means term x^k is in the polynomial
    function automatic logic [31:0] max_taps(input int width);
        logic [31:0] t;
        case (width)
            3:       t = 32'h0000_0006;
            4:       t = 32'h0000_000C;
            5:       t = 32'h0000_0014;
            6:       t = 32'h0000_0030;
            7:       t = 32'h0000_0060;
            8:       t = 32'h0000_00B8;
            9:       t = 32'h0000_0110;
            10:      t = 32'h0000_0240;
            11:      t = 32'h0000_0500;
            12:      t = 32'h0000_0829;
            13:      t = 32'h0000_100D;
            14:      t = 32'h0000_2015;
            15:      t = 32'h0000_6000;
            16:      t = 32'h0000_D008;
            17:      t = 32'h0001_2000;
            18:      t = 32'h0002_0400;
            19:      t = 32'h0004_0023;
            20:      t = 32'h0009_0000;
            21:      t = 32'h0014_0000;
            22:      t = 32'h0030_0000;
            23:      t = 32'h0042_0000;
            24:      t = 32'h00E1_0000;
            25:      t = 32'h0120_0000;
            26:      t = 32'h0200_0023;
            27:      t = 32'h0400_0013;
            28:      t = 32'h0900_0000;
            29:      t = 32'h1400_0000;
            30:      t = 32'h2000_0029;
            31:      t = 32'h4800_0000;
            32:      t = 32'h8020_0003;
            default: t = 32'h0000_0000;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/lfsr_sym_map.sv
// Combinational map from the two LFSR MSBs to a signed symbol.
module lfsr_sym_map
    import lfsr_pkg::*;
#(
    parameter int OUT_MODE = OUT_2LVL
) (
    input  logic [1:0] msb_i,
    output sym_t       sym_o
);

    // 2-level uses only the top bit; PAM-4 uses both bits Gray-coded
    always_comb begin
        sym_o = LVL_M1;
        if (OUT_MODE == OUT_PAM4)
            sym_o = gray_pam4(msb_i);
        else
            sym_o = msb_i[1] ? LVL_P1 : LVL_M1;
    end

endmodule

// File: rtl/lfsr_prbs_gen.sv
// Fibonacci LFSR PRBS source with seed load, clock enable, period
// tracking, zero-state recovery and registered symbol output.
module lfsr_prbs_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH    = 22,
    parameter logic [WIDTH-1:0] TAPS     = 22'h300000,
    parameter logic [WIDTH-1:0] SEED     = 22'h2FFFFF,
    parameter int               OUT_MODE = OUT_2LVL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             enable,
    output logic [WIDTH-1:0] state,
    output sym_t             sym,
    output logic             sym_valid,
    output logic             cycle,
    output logic             lockup
);

    // Last count value before wrap: the advance taken here is step 2^WIDTH-1
    localparam logic [WIDTH-1:0] CNT_LAST = {WIDTH{1'b1}} - WIDTH'(1);

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    sym_t             sym_q, sym_d;
    logic             sym_valid_q, cycle_q, lockup_q;
    logic             adv, wrap, lock;
    logic             fb;

    assign fb = ^(state_q & TAPS);

    // Next state: reset > load > zero-state guard > enable > hold
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adv     = 1'b0;
        lock    = 1'b0;
        if (reset) begin
            state_d = SEED;
            cnt_d   = '0;
        end else if (load) begin
            cnt_d = '0;
            if (seed != '0) begin
                state_d = seed;
            end else begin
                state_d = SEED;
                lock    = 1'b1;
            end
        end else if (state_q == '0) begin
            state_d = SEED;
            cnt_d   = '0;
            lock    = 1'b1;
        end else if (enable) begin
            adv     = 1'b1;
            state_d = {state_q[WIDTH-2:0], fb};
            cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + WIDTH'(1);
        end
    end

    assign wrap = adv && (cnt_q == CNT_LAST);

    // Symbol is mapped from the next state so it always matches state
    lfsr_sym_map #(
        .OUT_MODE (OUT_MODE)
    ) u_map (
        .msb_i (state_d[WIDTH-1:WIDTH-2]),
        .sym_o (sym_d)
    );

    // State, counter, symbol and one-cycle status pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SEED;
            cnt_q       <= '0;
            sym_q       <= sym_d;   // sym_d is the map of SEED while reset is high
            sym_valid_q <= 1'b0;
            cycle_q     <= 1'b0;
            lockup_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sym_q       <= sym_d;
            sym_valid_q <= adv;
            cycle_q     <= wrap;
            lockup_q    <= lock;
        end
    end

    assign state     = state_q;
    assign sym       = sym_q;
    assign sym_valid = sym_valid_q;
    assign cycle     = cycle_q;
    assign lockup    = lockup_q;

endmodule
